// File: rtl/token_doubler_arbiter.sv
// token_doubler_arbiter
//
// Round-robin owner of a single serial token-doubling datapath shared by N
// serial requesters. One requester at a time is granted. Its input stream is
// forwarded to the datapath and the doubled stream is routed back to it. The
// grant is released only after the stream ends and the datapath has drained
// (dp_b sampled 0). A datapath overflow resets the datapath for one cycle and
// latches a sticky per-requester error. That requester is then locked out
// until global reset.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   req[N]       per-requester request level, held high for a whole stream
//   a_in[N]      per-requester serial token input
//   b_out[N]     doubled stream, only on the granted requester's bit
//   grant[N]     registered one-hot (or zero) grant
//   err[N]       sticky per-requester overflow flag
//   busy         controller not idle
//   dp_a         datapath token input
//   dp_rst       datapath reset
//   dp_b         datapath output (registered inside the datapath, lags dp_a by 1)
//   dp_overflow  datapath sticky overflow
module token_doubler_arbiter #(
    parameter int N       = 4,
    parameter int QUANTUM = 64,
    parameter int CNT_W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] a_in,
    output logic [N-1:0] b_out,
    output logic [N-1:0] grant,
    output logic [N-1:0] err,
    output logic         busy,
    output logic         dp_a,
    output logic         dp_rst,
    input  logic         dp_b,
    input  logic         dp_overflow
);
    localparam int IDX_W = $clog2(N);
    localparam logic [CNT_W-1:0] QUANTUM_C = CNT_W'(QUANTUM);
    localparam logic [CNT_W-1:0] BEATS_MAX = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, RECOVER} state_t;

    state_t             state, state_nxt;
    logic [N-1:0]       grant_q, grant_nxt;
    logic [N-1:0]       err_q, err_nxt;
    logic [IDX_W-1:0]   last_q, last_nxt;
    logic [CNT_W-1:0]   beats_q, beats_nxt;

    logic [N-1:0]       eligible;
    logic [IDX_W-1:0]   gidx;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   cand;
    logic               found;
    logic               others;
    logic               preempt;

    assign eligible = req & ~err_q;
    assign err      = err_q;

    // Index of the current holder; only meaningful while grant_q is non-zero.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) gidx = IDX_W'(i);
        end
    end

    // Round-robin search starting just after the previous holder.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(last_q) + k) % N);
            if (!found && eligible[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // Another eligible requester is waiting behind the holder.
    assign others  = |(eligible & ~grant_q);
    // Preemption only ever lands on a 0 beat so a token is never split.
    assign preempt = (beats_q >= QUANTUM_C) && !a_in[gidx] && others;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= '0;
            err_q   <= '0;
            last_q  <= IDX_W'(N - 1);
            beats_q <= '0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            err_q   <= err_nxt;
            last_q  <= last_nxt;
            beats_q <= beats_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        err_nxt   = err_q;
        last_nxt  = last_q;
        beats_nxt = beats_q;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    grant_nxt       = '0;
                    grant_nxt[pick] = 1'b1;
                    beats_nxt       = '0;
                    state_nxt       = RUN;
                end
            end
            RUN: begin
                if (beats_q != BEATS_MAX) beats_nxt = beats_q + 1'b1;
                if (dp_overflow) begin
                    err_nxt[gidx] = 1'b1;
                    grant_nxt     = '0;
                    last_nxt      = gidx;
                    state_nxt     = RECOVER;
                end else if (!req[gidx] || preempt) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Request level is ignored here: the drain always completes.
                if (dp_overflow) begin
                    err_nxt[gidx] = 1'b1;
                    grant_nxt     = '0;
                    last_nxt      = gidx;
                    state_nxt     = RECOVER;
                end else if (!dp_b) begin
                    grant_nxt = '0;
                    last_nxt  = gidx;
                    state_nxt = IDLE;
                end
            end
            RECOVER: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic. Reset masks the registered outputs at once so the
    // datapath and requesters see a released bus in the reset cycle itself.
    always_comb begin
        grant  = grant_q;
        busy   = (state != IDLE);
        dp_a   = 1'b0;
        dp_rst = (state == RECOVER);
        b_out  = '0;
        case (state)
            RUN: begin
                dp_a  = a_in[gidx];
                b_out = grant_q & {N{dp_b}};
            end
            DRAIN: begin
                b_out = grant_q & {N{dp_b}};
            end
            default: ;
        endcase
        if (rst) begin
            grant  = '0;
            busy   = 1'b0;
            dp_a   = 1'b0;
            dp_rst = 1'b1;
            b_out  = '0;
        end
    end

endmodule

// File: tb/tb_token_doubler_arbiter.sv
// Testbench for token_doubler_arbiter. Provides a behavioural token-doubling
// datapath (each 1 beat adds two tokens, one token leaves per cycle, overflow
// once more than CAP tokens are held). A cycle-level reference model of the
// sharing rules pushes expected outputs into a scoreboard. A monitor pops and
// compares them on the falling edge.
module tb_token_doubler_arbiter;
    localparam int N   = 4;
    localparam int Q   = 4;
    localparam int CW  = 8;
    localparam int CAP = 200;

    typedef struct {
        logic [N-1:0] grant;
        logic [N-1:0] b_out;
        logic [N-1:0] err;
        logic         busy;
        logic         dp_a;
        logic         dp_rst;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] a_in = '0;
    logic [N-1:0] b_out, grant, err;
    logic         busy, dp_a, dp_rst, dp_b, dp_overflow;

    always #5 clk = ~clk;

    token_doubler_arbiter #(.N(N), .QUANTUM(Q), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_out(b_out),
        .grant(grant), .err(err), .busy(busy), .dp_a(dp_a), .dp_rst(dp_rst),
        .dp_b(dp_b), .dp_overflow(dp_overflow)
    );

    // One datapath step: tokens held -> tokens held next, output bit, overflow.
    function automatic void dstep(input int cnt, input bit a, output int ncnt,
                                  output bit nb, output bit so);
        int t;
        t    = cnt + (a ? 2 : 0);
        nb   = (t > 0);
        ncnt = (t > 0) ? t - 1 : 0;
        so   = (ncnt > CAP);
    endfunction

    // Environment datapath, driven by the DUT.
    int   env_cnt = 0;
    logic env_b   = 1'b0;
    logic env_ovf = 1'b0;
    int   env_nc;
    bit   env_nb, env_so;
    assign dp_b        = env_b;
    assign dp_overflow = env_ovf;
    always_comb dstep(env_cnt, dp_a, env_nc, env_nb, env_so);
    always @(posedge clk) begin
        if (dp_rst) begin
            env_cnt <= 0;
            env_b   <= 1'b0;
            env_ovf <= 1'b0;
        end else begin
            env_cnt <= env_nc;
            env_b   <= env_nb;
            if (env_so) env_ovf <= 1'b1;
        end
    end

    // Reference model: who owns the datapath and in which phase.
    localparam int P_IDLE = 0, P_STREAM = 1, P_FLUSH = 2, P_FIX = 3;
    int           m_phase, m_owner, m_last, m_beats, m_grants;
    logic [N-1:0] m_err;
    int           m_cnt;
    bit           m_b, m_ovf;

    task automatic m_reset();
        m_phase = P_IDLE; m_owner = -1; m_last = N - 1; m_beats = 0;
        m_err = '0; m_cnt = 0; m_b = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic m_fault();
        m_err[m_owner] = 1'b1;
        m_last  = m_owner;
        m_owner = -1;
        m_phase = P_FIX;
    endtask

    task automatic model_cycle(input logic [N-1:0] r, input logic [N-1:0] a,
                               input logic rs, output exp_t e);
        logic [N-1:0] elig;
        int nc; bit nb, so;
        elig = r & ~m_err;
        e.grant = '0; e.b_out = '0; e.err = m_err;
        e.busy = 1'b0; e.dp_a = 1'b0; e.dp_rst = 1'b0;
        if (rs) begin
            e.dp_rst = 1'b1;
            m_reset();
        end else begin
            case (m_phase)
                P_IDLE: begin
                    for (int k = 1; k <= N; k++) begin
                        if (m_owner < 0 && elig[(m_last + k) % N]) m_owner = (m_last + k) % N;
                    end
                    if (m_owner >= 0) begin
                        m_phase = P_STREAM; m_beats = 0; m_grants++;
                    end
                end
                P_STREAM: begin
                    e.grant[m_owner] = 1'b1;
                    e.busy = 1'b1;
                    e.dp_a = a[m_owner];
                    e.b_out = m_b ? e.grant : '0;
                    if (m_ovf) m_fault();
                    else if (!r[m_owner] || (m_beats >= Q && !a[m_owner] && (elig & ~e.grant) != 0))
                        m_phase = P_FLUSH;
                    m_beats = (m_beats < (1 << CW) - 1) ? m_beats + 1 : m_beats;
                end
                P_FLUSH: begin
                    e.grant[m_owner] = 1'b1;
                    e.busy = 1'b1;
                    e.b_out = m_b ? e.grant : '0;
                    if (m_ovf) m_fault();
                    else if (!m_b) begin
                        m_last = m_owner; m_owner = -1; m_phase = P_IDLE;
                    end
                end
                default: begin
                    e.busy = 1'b1;
                    e.dp_rst = 1'b1;
                    m_phase = P_IDLE;
                end
            endcase
            if (e.dp_rst) begin
                m_cnt = 0; m_b = 1'b0; m_ovf = 1'b0;
            end else begin
                dstep(m_cnt, e.dp_a, nc, nb, so);
                m_cnt = nc; m_b = nb;
                if (so) m_ovf = 1'b1;
            end
        end
    endtask

    // Scoreboard
    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   gq[$];
    int   bones[N];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        logic [N-1:0] prev_g;
        prev_g = '0;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("grant",  32'(grant),  32'(e.grant));
                chk("b_out",  32'(b_out),  32'(e.b_out));
                chk("err",    32'(err),    32'(e.err));
                chk("busy",   32'(busy),   32'(e.busy));
                chk("dp_a",   32'(dp_a),   32'(e.dp_a));
                chk("dp_rst", 32'(dp_rst), 32'(e.dp_rst));
            end
            if (grant != '0 && prev_g == '0) begin
                for (int i = 0; i < N; i++) if (grant[i]) gq.push_back(i);
            end
            for (int i = 0; i < N; i++) if (b_out[i] === 1'b1) bones[i]++;
            prev_g = grant;
        end
    end

    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] a, input logic rs);
        exp_t e;
        @(posedge clk);
        #1;
        req = r; a_in = a; rst = rs;
        model_cycle(r, a, rs, e);
        sbq.push_back(e);
    endtask

    task automatic do_rst();
        repeat (2) cyc('0, '0, 1'b1);
        gq.delete();
        for (int i = 0; i < N; i++) bones[i] = 0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin : stim
        logic [N-1:0] rv, av, nr;
        int sp[5];
        int rr_exp[5];
        int g0;
        bit drop_all;
        sp = '{1, 0, 0, 1, 0};
        rr_exp = '{0, 1, 2, 3, 0};
        m_reset();
        repeat (3) cyc('0, '0, 1'b1);

        // Single requester: 1,0,0,1,0 doubles to four 1s on b_out[0].
        do_rst();
        cyc(4'b0001, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            av = '0; av[0] = (sp[i] != 0);
            cyc(4'b0001, av, 1'b0);
        end
        repeat (6) cyc('0, '0, 1'b0);
        settle();
        chk("single_b_ones", 32'(bones[0]), 32'd4);

        // Round-robin: every stream is three 0 beats, then the request drops.
        do_rst();
        g0 = m_grants; drop_all = 1'b0;
        for (int c = 0; c < 400; c++) begin
            nr = drop_all ? '0 : '1;
            if (m_phase == P_STREAM && m_beats == 3) begin
                nr[m_owner] = 1'b0;
                if (m_grants - g0 == 5) begin
                    drop_all = 1'b1; nr = '0;
                end
            end
            cyc(nr, '0, 1'b0);
            if (drop_all && m_phase == P_IDLE) break;
        end
        repeat (3) cyc('0, '0, 1'b0);
        settle();
        chk("rr_count", 32'(gq.size()), 32'd5);
        for (int i = 0; i < 5; i++) if (i < gq.size()) chk("rr_order", 32'(gq[i]), 32'(rr_exp[i]));

        // Drain hold: five 1s from requester 2, requester 0 waits behind it.
        do_rst();
        cyc(4'b0100, '0, 1'b0);
        repeat (5) cyc(4'b0100, 4'b0100, 1'b0);
        repeat (12) cyc(4'b0001, '0, 1'b0);
        repeat (5) cyc('0, '0, 1'b0);
        settle();
        chk("drain_b_ones", 32'(bones[2]), 32'd10);
        chk("drain_first", 32'(gq.size() > 0 ? gq[0] : -1), 32'd2);
        chk("drain_second", 32'(gq.size() > 1 ? gq[1] : -1), 32'd0);

        // Preemption after the quantum, on the first 0 beat only.
        do_rst();
        cyc(4'b0001, '0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(4'b0011, (i < 5) ? 4'b0001 : 4'b0000, 1'b0);
        repeat (10) cyc('0, '0, 1'b0);
        settle();
        chk("preempt_first", 32'(gq.size() > 0 ? gq[0] : -1), 32'd0);
        chk("preempt_second", 32'(gq.size() > 1 ? gq[1] : -1), 32'd1);

        // Overflow: requester 1 streams 1s until the datapath overflows.
        do_rst();
        cyc(4'b0010, '0, 1'b0);
        repeat (210) cyc(4'b0010, 4'b0010, 1'b0);
        for (int i = 0; i < 60; i++) begin
            av = N'($urandom());
            cyc(4'b1111, av, 1'b0);
        end
        settle();
        chk("ovf_err", 32'(err), 32'b0010);
        chk("ovf_bit1_grants", 32'(gq.size() > 1 ? (gq[1] != 1) : 0), 32'd1);
        do_rst();
        cyc('0, '0, 1'b0);
        settle();
        chk("ovf_err_cleared", 32'(err), 32'd0);

        // Mid-run reset while requester 3 holds the datapath.
        do_rst();
        cyc(4'b1000, '0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            av = '0; av[3] = 1'($urandom_range(1));
            cyc(4'b1000, av, 1'b0);
        end
        repeat (2) cyc(4'b1001, '0, 1'b1);
        gq.delete();
        repeat (6) cyc(4'b1001, '0, 1'b0);
        repeat (8) cyc('0, '0, 1'b0);
        settle();
        chk("midrst_first", 32'(gq.size() > 0 ? gq[0] : -1), 32'd0);

        // Random traffic with occasional resets.
        do_rst();
        rv = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) rv[i] = ~rv[i];
            av = N'($urandom());
            cyc(rv, av, ($urandom_range(399) == 0));
        end
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
